// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding buffer per functional unit, round-robin
// selection of up to N_WAY buffered results per cycle onto registered CDB slots.
`ifndef N_WAY
`define N_WAY 2
`endif
`ifndef CDB_BITS
`define CDB_BITS 6
`endif

module cdb_arbiter #(
   parameter int N_REQ  = 6,
   parameter int N_WAY  = `N_WAY,
   parameter int TAG_W  = `CDB_BITS,
   parameter int DATA_W = 64
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [N_REQ-1:0]             fu_valid,
   input  logic [N_REQ-1:0][TAG_W-1:0]  fu_tag,
   input  logic [N_REQ-1:0][DATA_W-1:0] fu_value,
   output logic [N_REQ-1:0]             fu_ready,
   input  logic                         flush,
   output logic [N_WAY-1:0]             cdb_valid,
   output logic [N_WAY-1:0][TAG_W-1:0]  cdb_tag,
   output logic [N_WAY-1:0][DATA_W-1:0] cdb_value,
   output logic [$clog2(N_REQ):0]       pending_count
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W = $clog2(N_REQ) + 1;

   logic [N_REQ-1:0]             buf_valid;
   logic [N_REQ-1:0][TAG_W-1:0]  buf_tag;
   logic [N_REQ-1:0][DATA_W-1:0] buf_value;
   logic [PTR_W-1:0]             rr_ptr;

   logic [N_REQ-1:0]             grant;
   logic [N_REQ-1:0]             load;
   logic [N_REQ-1:0]             valid_nxt;
   logic [N_WAY-1:0]             slot_valid;
   logic [N_WAY-1:0][TAG_W-1:0]  slot_tag;
   logic [N_WAY-1:0][DATA_W-1:0] slot_value;
   logic [PTR_W-1:0]             rr_nxt;
   logic [CNT_W-1:0]             count_nxt;
   logic [PTR_W-1:0]             idx;
   int unsigned                  n_used;
   int unsigned                  pos;
   int unsigned                  last_pos;

   // Scan from rr_ptr, filling slots in scan order until all ways are used.
   always_comb begin
      grant      = '0;
      slot_valid = '0;
      slot_tag   = '0;
      slot_value = '0;
      n_used     = 0;
      pos        = 0;
      idx        = '0;
      last_pos   = 32'(rr_ptr);
      for (int unsigned k = 0; k < N_REQ; k++) begin
         pos = 32'(rr_ptr) + k;
         if (pos >= N_REQ) pos = pos - N_REQ;
         idx = PTR_W'(pos);
         if (buf_valid[idx] && n_used < N_WAY) begin
            grant[idx] = 1'b1;
            for (int unsigned s = 0; s < N_WAY; s++) begin
               if (s == n_used) begin
                  slot_valid[s] = 1'b1;
                  slot_tag[s]   = buf_tag[idx];
                  slot_value[s] = buf_value[idx];
               end
            end
            last_pos = pos;
            n_used   = n_used + 1;
         end
      end
      rr_nxt = (last_pos + 1 >= N_REQ) ? '0 : PTR_W'(last_pos + 1);
   end

   // Ready depends only on registered state; a granted buffer may reload this cycle.
   assign fu_ready = ~buf_valid | grant;

   always_comb begin
      count_nxt = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         load[i]      = fu_valid[i] && fu_ready[i] && (fu_tag[i] != '0);
         valid_nxt[i] = load[i] || (buf_valid[i] && !grant[i]);
         count_nxt    = count_nxt + CNT_W'(valid_nxt[i]);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         buf_valid     <= '0;
         buf_tag       <= '0;
         buf_value     <= '0;
         rr_ptr        <= '0;
         cdb_valid     <= '0;
         cdb_tag       <= '0;
         cdb_value     <= '0;
         pending_count <= '0;
      end else if (flush) begin
         buf_valid     <= '0;
         cdb_valid     <= '0;
         cdb_tag       <= '0;
         cdb_value     <= '0;
         pending_count <= '0;
      end else begin
         buf_valid <= valid_nxt;
         for (int unsigned i = 0; i < N_REQ; i++) begin
            if (load[i]) begin
               buf_tag[i]   <= fu_tag[i];
               buf_value[i] <= fu_value[i];
            end
         end
         cdb_valid     <= slot_valid;
         cdb_tag       <= slot_tag;
         cdb_value     <= slot_value;
         pending_count <= count_nxt;
         if (|grant) rr_ptr <= rr_nxt;
      end
   end

endmodule
